cpu_instruction_cache_lf: RTL and testbench

- Parametrised successor to the direct-mapped instruction cache: tag/valid arrays per line, multi-word lines, critical-word-first line fill with wrap, and explicit flush.
- Sits between the CPU fetch stage and the memory arbiter.
- Same request/response memory port style: address plus read request out; success, returned address and data in.

---
 rtl/cpu_instruction_cache_lf.sv | 195 +++++++++++++++++++
 tb/tb_cpu_instruction_cache_lf.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_instruction_cache_lf.sv
// cpu_instruction_cache_lf
//   Direct-mapped instruction cache with multi-word lines. A miss fills the
//   whole line starting at the missed (critical) word and wrapping inside
//   the line; returned words become usable one by one as they arrive.
//   A flush pulse invalidates every line, deferred until any fill is done.
//
//   Optional build macro: ICACHE_PERF_COUNTERS_EN adds perf_hits/perf_misses.
//
// Ports
//   CLK, RSTb                 clock, async active-low reset
//   cache_request_address     fetch address, registered every cycle
//   address_data, cache_miss  lookup result for the registered address
//   flush, flush_busy         invalidate-all request / pending indication
//   memory_address, memory_rd_req, will_queue   fill request handshake
//   memory_success, memory_requested_address, memory_data   fill returns
//   perf_hits, perf_misses    (macro only) saturating event counters
module cpu_instruction_cache_lf #(
  parameter int ADDR_BITS  = 15,
  parameter int DATA_BITS  = 16,
  parameter int INDEX_BITS = 4,
  parameter int WORD_BITS  = 3
) (
  input  logic                 CLK,
  input  logic                 RSTb,
  input  logic [ADDR_BITS-1:0] cache_request_address,
  output logic [DATA_BITS-1:0] address_data,
  output logic                 cache_miss,
  input  logic                 flush,
  output logic                 flush_busy,
  output logic [ADDR_BITS-1:0] memory_address,
  output logic                 memory_rd_req,
  input  logic                 will_queue,
  input  logic                 memory_success,
  input  logic [ADDR_BITS-1:0] memory_requested_address,
  input  logic [DATA_BITS-1:0] memory_data
`ifdef ICACHE_PERF_COUNTERS_EN
  ,
  output logic [31:0]          perf_hits,
  output logic [31:0]          perf_misses
`endif
);
  localparam int TAG_BITS  = ADDR_BITS - INDEX_BITS - WORD_BITS;
  localparam int LINE_BITS = ADDR_BITS - WORD_BITS;
  localparam int LINES     = 1 << INDEX_BITS;
  localparam int WORDS     = 1 << WORD_BITS;

  typedef enum logic [1:0] {IDLE, FILL_ISSUE, FILL_WAIT, FLUSH} state_t;

  state_t                 state, state_n;
  logic [ADDR_BITS-1:0]   address_x;
  logic [LINES-1:0]       valid;
  logic [TAG_BITS-1:0]    tag_ram  [LINES];
  logic [DATA_BITS-1:0]   data_ram [LINES*WORDS];
  logic [LINE_BITS-1:0]   fill_line;
  logic [WORD_BITS-1:0]   start_word;
  logic [WORD_BITS-1:0]   issue_cnt;
  logic [WORDS-1:0]       fill_mask;

  // registered address fields
  logic [TAG_BITS-1:0]    x_tag;
  logic [INDEX_BITS-1:0]  x_idx;
  logic [WORD_BITS-1:0]   x_word;
  logic [LINE_BITS-1:0]   x_line;
  logic [INDEX_BITS-1:0]  fill_idx;
  logic [WORD_BITS-1:0]   ret_word;

  assign x_tag    = address_x[ADDR_BITS-1 -: TAG_BITS];
  assign x_idx    = address_x[WORD_BITS +: INDEX_BITS];
  assign x_word   = address_x[WORD_BITS-1:0];
  assign x_line   = address_x[ADDR_BITS-1:WORD_BITS];
  assign fill_idx = fill_line[INDEX_BITS-1:0];
  assign ret_word = memory_requested_address[WORD_BITS-1:0];

  // A word of the line being filled is usable as soon as its own return
  // has landed, before the whole line is marked valid.
  logic hit_tag, hit_fill, ret_ok, start_fill, fill_done, do_flush, issue_adv;
  logic [WORDS-1:0] ret_bit, mask_next;

  assign hit_tag      = valid[x_idx] && (tag_ram[x_idx] == x_tag);
  assign hit_fill     = (state != IDLE) && (fill_line == x_line) && fill_mask[x_word];
  assign cache_miss   = !(hit_tag || hit_fill);
  assign address_data = data_ram[address_x[INDEX_BITS+WORD_BITS-1:0]];

  // Only returns belonging to the active fill line are accepted; strays and
  // anything arriving while IDLE (e.g. after a reset mid-fill) are dropped.
  assign ret_ok = ((state == FILL_ISSUE) || (state == FILL_WAIT)) && memory_success &&
                  (memory_requested_address[ADDR_BITS-1:WORD_BITS] == fill_line);

  always_comb begin
    ret_bit           = '0;
    ret_bit[ret_word] = ret_ok;
  end
  assign mask_next = fill_mask | ret_bit;

  // Critical word first: offset wraps modulo the line size.
  assign memory_address = {fill_line, start_word + issue_cnt};
  assign issue_adv      = (state == FILL_ISSUE) && will_queue;

  always_comb begin
    state_n       = state;
    start_fill    = 1'b0;
    fill_done     = 1'b0;
    do_flush      = 1'b0;
    memory_rd_req = 1'b0;
    case (state)
      IDLE: begin
        if (flush_busy) begin
          state_n = FLUSH;
        end else if (cache_miss) begin
          start_fill = 1'b1;
          state_n    = FILL_ISSUE;
        end
      end
      FILL_ISSUE: begin
        memory_rd_req = 1'b1;
        if (will_queue && (&issue_cnt)) state_n = FILL_WAIT;
      end
      FILL_WAIT: begin
        // completion may coincide with the last return
        if (&mask_next) begin
          fill_done = 1'b1;
          state_n   = IDLE;
        end
      end
      FLUSH: begin
        do_flush = 1'b1;
        state_n  = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state      <= IDLE;
      address_x  <= '0;
      valid      <= '0;
      fill_mask  <= '0;
      flush_busy <= 1'b0;
      issue_cnt  <= '0;
      fill_line  <= '0;
      start_word <= '0;
    end else begin
      state     <= state_n;
      address_x <= cache_request_address;
      // a new pulse wins over the clear so it is never lost
      if (flush)         flush_busy <= 1'b1;
      else if (do_flush) flush_busy <= 1'b0;
      if (start_fill) begin
        fill_line  <= x_line;
        start_word <= x_word;
        issue_cnt  <= '0;
        fill_mask  <= '0;
      end else begin
        if (issue_adv) issue_cnt <= issue_cnt + WORD_BITS'(1);
        if (ret_ok)    fill_mask <= mask_next;
      end
      if (do_flush) begin
        valid <= '0;
      end else begin
        if (start_fill) valid[x_idx]    <= 1'b0;
        if (fill_done)  valid[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag/data storage carries no reset; the valid bits qualify it.
  always_ff @(posedge CLK) begin
    if (start_fill) tag_ram[x_idx] <= x_tag;
    if (ret_ok)     data_ram[memory_requested_address[INDEX_BITS+WORD_BITS-1:0]] <= memory_data;
  end

`ifdef ICACHE_PERF_COUNTERS_EN
  logic [ADDR_BITS-1:0] address_prev;

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      address_prev <= '0;
      perf_hits    <= '0;
      perf_misses  <= '0;
    end else begin
      address_prev <= address_x;
      if (flush) begin
        perf_hits   <= '0;
        perf_misses <= '0;
      end else begin
        if ((address_x != address_prev) && !cache_miss && (perf_hits != '1))
          perf_hits <= perf_hits + 32'd1;
        if (start_fill && (perf_misses != '1))
          perf_misses <= perf_misses + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cpu_instruction_cache_lf.sv
// Bench for cpu_instruction_cache_lf: acts as CPU and memory arbiter.
// The reference model tracks which line (tag) is resident per index, the
// expected fill issue order, and which words memory has returned; memory
// content is a fixed function of the address.
module tb_cpu_instruction_cache_lf;
  logic        CLK = 1'b0;
  logic        RSTb = 1'b0;
  logic [14:0] cache_request_address = '0;
  logic [15:0] address_data;
  logic        cache_miss;
  logic        flush = 1'b0;
  logic        flush_busy;
  logic [14:0] memory_address;
  logic        memory_rd_req;
  logic        will_queue = 1'b0;
  logic        memory_success = 1'b0;
  logic [14:0] memory_requested_address = '0;
  logic [15:0] memory_data = '0;
`ifdef ICACHE_PERF_COUNTERS_EN
  logic [31:0] perf_hits, perf_misses;
`endif

  cpu_instruction_cache_lf dut (
    .CLK(CLK), .RSTb(RSTb),
    .cache_request_address(cache_request_address),
    .address_data(address_data), .cache_miss(cache_miss),
    .flush(flush), .flush_busy(flush_busy),
    .memory_address(memory_address), .memory_rd_req(memory_rd_req),
    .will_queue(will_queue), .memory_success(memory_success),
    .memory_requested_address(memory_requested_address),
    .memory_data(memory_data)
`ifdef ICACHE_PERF_COUNTERS_EN
    , .perf_hits(perf_hits), .perf_misses(perf_misses)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          res_v   [16];
  logic [7:0]  res_tag [16];
  logic [14:0] exp_q[$], pending[$], issued[$];
  bit          returned[logic [14:0]];
  logic [14:0] ax = '0;
  bit          last_ret_v = 0;
  logic [14:0] last_ret;

  int  wq_pct = 100, ret_pct = 100, ret_budget = -1, force_wq0 = 0;
  bit  ooo = 0, stray_now = 0, stray_cyc = 0;
  logic [14:0] stray_addr;
  logic [15:0] stray_data;

  function automatic logic [15:0] mem_fn(input logic [14:0] a);
    logic [15:0] p;
    p = 16'(a) * 16'd40503;
    return p ^ 16'h1234;
  endfunction

  function automatic bit model_miss(input logic [14:0] a);
    return !(res_v[a[6:3]] && res_tag[a[6:3]] == a[14:7]);
  endfunction

  task automatic seed(input logic [14:0] a);
    logic [2:0] w;
    for (int k = 0; k < 8; k++) begin
      w = a[2:0] + 3'(k);
      exp_q.push_back({a[14:3], w});
    end
  endtask

  task automatic model_reset();
    exp_q.delete(); returned.delete();
    for (int i = 0; i < 16; i++) res_v[i] = 0;
    last_ret_v = 0; ax = '0;
  endtask

  // One clock cycle: drive memory side, observe, advance.
  task automatic tick();
    int i;
    logic [14:0] ra;
    if (force_wq0 > 0) begin will_queue = 1'b0; force_wq0--; end
    else will_queue = ($urandom_range(99) < wq_pct);
    stray_cyc = 0; memory_success = 1'b0; memory_requested_address = '0; memory_data = '0;
    if (stray_now) begin
      memory_success = 1'b1; memory_requested_address = stray_addr; memory_data = stray_data;
      stray_cyc = 1; stray_now = 0;
    end else if (pending.size() > 0 && ret_budget != 0 && $urandom_range(99) < ret_pct) begin
      i = ooo ? int'($urandom_range(pending.size() - 1)) : 0;
      ra = pending[i]; pending.delete(i);
      memory_success = 1'b1; memory_requested_address = ra; memory_data = mem_fn(ra);
      if (ret_budget > 0) ret_budget--;
    end
    #1;
    if (last_ret_v && last_ret == ax) chk("hit_after_ret", cache_miss, 0);
    if (!cache_miss) begin
      chk("hit_data", address_data, mem_fn(ax));
      chk("hit_known", returned.exists(ax), 1);
    end
    if (memory_rd_req && will_queue) begin
      if (exp_q.size() == 0) chk("issue_expected", 0, 1);
      else chk("issue_addr", memory_address, exp_q.pop_front());
      pending.push_back(memory_address);
      issued.push_back(memory_address);
    end
    last_ret_v = memory_success && !stray_cyc;
    if (last_ret_v) begin
      last_ret = memory_requested_address;
      returned[memory_requested_address] = 1;
    end
    @(posedge CLK);
    ax = cache_request_address;
    #1;
  endtask

  task automatic finish_fill(input logic [14:0] a);
    int n = 0;
    while (n < 400 && (exp_q.size() > 0 || pending.size() > 0 || memory_rd_req)) begin
      tick(); n++;
    end
    chk("fill_done", (n < 400), 1);
    tick();
    res_v[a[6:3]] = 1; res_tag[a[6:3]] = a[14:7];
  endtask

  task automatic fetch(input logic [14:0] a);
    bit em;
    cache_request_address = a;
    tick();
    em = model_miss(a);
    chk("miss", cache_miss, em);
    if (em) begin
      seed(a);
      finish_fill(a);
      chk("hit_after_fill", cache_miss, 0);
    end
  endtask

  task automatic flush_idle();
    int n = 0;
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_busy_set", flush_busy, 1);
    while (flush_busy && n < 10) begin tick(); n++; end
    chk("flush_cycles", n, 2);
    for (int i = 0; i < 16; i++) res_v[i] = 0;
    chk("miss_after_flush", cache_miss, 1);
    seed(ax);
    finish_fill(ax);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] t1_exp[8] = '{15'h13, 15'h14, 15'h15, 15'h16, 15'h17, 15'h10, 15'h11, 15'h12};
    logic [14:0] held, ra;
    int n;

    // reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_miss", cache_miss, 1);
    chk("rst_rd_req", memory_rd_req, 0);
    chk("rst_flush_busy", flush_busy, 0);
    RSTb = 1'b1;
    // address 0 is registered out of reset and misses: let that fill run
    seed(15'h0);
    finish_fill(15'h0);

    // T1: critical word first with wrap
    ret_budget = 0;
    cache_request_address = 15'h13;
    tick();
    chk("t1_miss", cache_miss, 1);
    seed(15'h13); issued.delete();
    n = 0;
    while (pending.size() < 8 && n < 50) begin tick(); n++; end
    chk("t1_issue_count", issued.size(), 8);
    for (int k = 0; k < 8 && k < issued.size(); k++) chk("t1_order", issued[k], t1_exp[k]);
    chk("t1_wait_miss", cache_miss, 1);
    ret_budget = 1;
    tick();
    chk("t1_crit_hit", cache_miss, 0);
    cache_request_address = 15'h10;
    tick();
    chk("t1_0010_early", cache_miss, 1);
    ret_budget = -1;
    n = 0;
    while (cache_miss && n < 50) begin tick(); n++; end
    chk("t1_0010_hit", cache_miss, 0);
    finish_fill(15'h13);

    // T2: arbiter stalls mid-issue
    cache_request_address = 15'h35;
    tick();
    chk("t2_miss", cache_miss, model_miss(15'h35));
    seed(15'h35);
    repeat (4) tick();
    chk("t2_stall_addr", memory_address, exp_q[0]);
    held = memory_address;
    force_wq0 = 5;
    repeat (5) begin
      tick();
      chk("t2_addr_hold", memory_address, held);
      chk("t2_rd_req", memory_rd_req, 1);
    end
    finish_fill(15'h35);
    chk("t2_hit", cache_miss, 0);
    fetch(15'h31);

    // T3: same index, different tag
    fetch(15'h020);
    fetch(15'h120);
    fetch(15'h020);

    // T5: flush during a fill is deferred
    cache_request_address = 15'h45;
    tick();
    chk("t5_miss", cache_miss, model_miss(15'h45));
    seed(15'h45);
    repeat (2) tick();
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t5_busy", flush_busy, 1);
    n = 0;
    while (n < 400 && (exp_q.size() > 0 || pending.size() > 0 || memory_rd_req)) begin
      chk("t5_busy_hold", flush_busy, 1);
      tick(); n++;
    end
    chk("t5_fill_done", (n < 400), 1);
    chk("t5_busy_after_fill", flush_busy, 1);
    n = 0;
    while (flush_busy && n < 10) begin tick(); n++; end
    chk("t5_flush_cycles", n, 2);
    for (int i = 0; i < 16; i++) res_v[i] = 0;
    chk("t5_refetch_miss", cache_miss, model_miss(15'h45));
    seed(15'h45);
    finish_fill(15'h45);

    // T6: async reset mid-fill
    ret_budget = 0;
    cache_request_address = 15'h57;
    tick();
    chk("t6_miss", cache_miss, model_miss(15'h57));
    seed(15'h57);
    repeat (3) tick();
    #2;
    RSTb = 1'b0;
    #1;
    chk("t6_rd_req_drop", memory_rd_req, 0);
    chk("t6_miss_now", cache_miss, 1);
    cache_request_address = '0;
    model_reset();
    tick();
    RSTb = 1'b1;
`ifdef ICACHE_PERF_COUNTERS_EN
    chk("t6_perf_hits", perf_hits, 0);
    chk("t6_perf_misses", perf_misses, 0);
`endif
    chk("t6_idle_miss", cache_miss, 1);
    if (pending.size() > 0) begin
      ra = pending[0];
      stray_addr = ra; stray_data = mem_fn(ra); stray_now = 1;
    end
    pending.delete();
    ret_budget = -1;
    seed(15'h0);
    finish_fill(15'h0);
    fetch(15'h57);

    // T4: stray return outside the fill line
    ret_budget = 0;
    cache_request_address = 15'h13;
    tick();
    chk("t4_miss", cache_miss, model_miss(15'h13));
    seed(15'h13);
    repeat (2) tick();
    stray_addr = 15'h400; stray_data = 16'hDEAD; stray_now = 1;
    tick();
    tick();
    chk("t4_no_hit", cache_miss, 1);
    cache_request_address = 15'h10;
    tick();
    chk("t4_mask_clean", cache_miss, 1);
    cache_request_address = 15'h13;
    ret_budget = -1;
    finish_fill(15'h13);
    chk("t4_hit", cache_miss, 0);
    fetch(15'h400);

    // random phase
    wq_pct = 70; ret_pct = 50; ooo = 1;
    for (int r = 0; r < 60; r++) begin
      logic [1:0] tg;
      logic [3:0] ix;
      logic [2:0] wd;
      tg = 2'($urandom_range(2));
      ix = 4'($urandom_range(15));
      wd = 3'($urandom_range(7));
      fetch({6'd0, tg, ix, wd});
      if (r % 15 == 14) flush_idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
